// File: rtl/spmm_pkg.sv
// rtl/spmm_pkg.sv - shared SpMM sizes and types (macros N, W, lgN, dbLgN)
`ifndef N
`define N 16
`endif
`ifndef W
`define W 8
`endif
`ifndef lgN
`define lgN $clog2(`N)
`endif
`ifndef dbLgN
`define dbLgN (2*$clog2(`N))
`endif

package spmm_pkg;
  localparam int N     = `N;
  localparam int W     = `W;
  localparam int lgN   = `lgN;
  localparam int dbLgN = `dbLgN;
  // nonzero count of one row needs to reach N itself
  localparam int CNT_W = lgN + 1;
  // staging occupancy reaches 2N-1
  localparam int OCC_W = lgN + 2;

  typedef logic [W-1:0]     data_t;
  typedef logic [lgN-1:0]   col_t;
  typedef logic [dbLgN-1:0] ptr_t;

  typedef enum logic [1:0] {FILL, SEND, SEND_LAST} state_t;
endpackage

// File: rtl/row_compactor.sv
// rtl/row_compactor.sv - combinational compaction of one dense row into nonzeros, columns, count
module row_compactor
  import spmm_pkg::*;
(
  input  data_t [N-1:0]    row,
  output data_t [N-1:0]    vals,
  output col_t  [N-1:0]    cols,
  output logic [CNT_W-1:0] count
);
  // running prefix count drops each nonzero into the next free slot, ascending column order
  always_comb begin
    vals  = '0;
    cols  = '0;
    count = '0;
    for (int j = 0; j < N; j++) begin
      if (row[j] != '0) begin
        vals[count[lgN-1:0]] = row[j];
        cols[count[lgN-1:0]] = col_t'(j);
        count = count + CNT_W'(1);
      end
    end
  end
endmodule

// File: rtl/csr_packer.sv
// rtl/csr_packer.sv - packs N dense rows into N-slot CSR beats for the SpMM lhs port (option CSR_PACKER_ZERO_BEAT_EN)
module csr_packer
  import spmm_pkg::*;
(
  input  logic          clock,
  input  logic          reset,
  input  logic          row_valid,
  output logic          row_ready,
  input  data_t [N-1:0] row_data,
  output logic          lhs_start,
  input  logic          lhs_ready,
  output ptr_t  [N-1:0] lhs_ptr,
  output col_t  [N-1:0] lhs_col,
  output data_t [N-1:0] lhs_data,
  output logic          lhs_last
);
  state_t            state_q, state_d;
  data_t [2*N-1:0]   stg_data_q, stg_data_app, stg_data_sh;
  col_t  [2*N-1:0]   stg_col_q, stg_col_app, stg_col_sh;
  logic [OCC_W-1:0]  occ_q, occ_app, cnt_ext, rel;
  col_t              row_q;
  ptr_t  [N-1:0]     ptr_q;
  ptr_t              total_q, total_app;
  logic              rows_done_q, any_nz_q;
  data_t [N-1:0]     comp_data;
  col_t  [N-1:0]     comp_col;
  logic [CNT_W-1:0]  comp_cnt;
  logic              accept, last_row, exact_last, matrix_empty, do_shift, do_clear;

  row_compactor u_comp (
    .row   (row_data),
    .vals  (comp_data),
    .cols  (comp_col),
    .count (comp_cnt)
  );

  assign accept       = row_valid && row_ready;
  assign last_row     = (row_q == col_t'(N - 1));
  assign cnt_ext      = OCC_W'(comp_cnt);
  assign occ_app      = occ_q + cnt_ext;
  assign total_app    = total_q + ptr_t'(comp_cnt);
  assign exact_last   = rows_done_q && (occ_q == OCC_W'(N));
  assign matrix_empty = !any_nz_q && (comp_cnt == '0);
  assign lhs_ptr      = ptr_q;

  // staging views: incoming row appended at occupancy, and contents after one beat leaves
  always_comb begin
    stg_data_app = stg_data_q;
    stg_col_app  = stg_col_q;
    rel          = '0;
    for (int j = 0; j < 2 * N; j++) begin
      rel = OCC_W'(j) - occ_q;
      if (OCC_W'(j) >= occ_q && rel < cnt_ext) begin
        stg_data_app[j] = comp_data[rel[lgN-1:0]];
        stg_col_app[j]  = comp_col[rel[lgN-1:0]];
      end
    end
    for (int j = 0; j < N; j++) begin
      stg_data_sh[j]     = stg_data_q[j+N];
      stg_col_sh[j]      = stg_col_q[j+N];
      stg_data_sh[j+N]   = '0;
      stg_col_sh[j+N]    = '0;
    end
  end

  // slots are driven only while a beat is offered; entries past occupancy are kept zero
  always_comb begin
    for (int k = 0; k < N; k++) begin
      lhs_data[k] = lhs_start ? stg_data_q[k] : '0;
      lhs_col[k]  = lhs_start ? stg_col_q[k]  : '0;
    end
  end

  // state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= FILL;
    else        state_q <= state_d;
  end

  // next state, handshakes and staging commands
  always_comb begin
    state_d   = state_q;
    row_ready = 1'b0;
    lhs_start = 1'b0;
    lhs_last  = 1'b0;
    do_shift  = 1'b0;
    do_clear  = 1'b0;
    case (state_q)
      FILL: begin
        row_ready = reset;
        if (accept) begin
          if (occ_app >= OCC_W'(N)) begin
            state_d = SEND;
          end else if (last_row) begin
            if (matrix_empty) begin
`ifdef CSR_PACKER_ZERO_BEAT_EN
              state_d = SEND_LAST;
`else
              do_clear = 1'b1;
`endif
            end else begin
              state_d = SEND_LAST;
            end
          end
        end
      end
      SEND: begin
        lhs_start = 1'b1;
        lhs_last  = exact_last;
        if (lhs_ready) begin
          do_shift = 1'b1;
          if (exact_last) begin
            do_clear = 1'b1;
            state_d  = FILL;
          end else if ((occ_q - OCC_W'(N)) >= OCC_W'(N)) begin
            state_d = SEND;
          end else if (rows_done_q) begin
            state_d = SEND_LAST;
          end else begin
            state_d = FILL;
          end
        end
      end
      SEND_LAST: begin
        lhs_start = 1'b1;
        lhs_last  = 1'b1;
        if (lhs_ready) begin
          do_clear = 1'b1;
          state_d  = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // staging buffer, occupancy, row counter and ptr table
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stg_data_q  <= '0;
      stg_col_q   <= '0;
      occ_q       <= '0;
      row_q       <= '0;
      ptr_q       <= '0;
      total_q     <= '0;
      rows_done_q <= 1'b0;
      any_nz_q    <= 1'b0;
    end else if (do_clear) begin
      stg_data_q  <= '0;
      stg_col_q   <= '0;
      occ_q       <= '0;
      row_q       <= '0;
      ptr_q       <= '0;
      total_q     <= '0;
      rows_done_q <= 1'b0;
      any_nz_q    <= 1'b0;
    end else if (accept) begin
      stg_data_q <= stg_data_app;
      stg_col_q  <= stg_col_app;
      occ_q      <= occ_app;
      row_q      <= row_q + col_t'(1);
      total_q    <= total_app;
      for (int k = 0; k < N; k++) begin
        if (col_t'(k) >= row_q) ptr_q[k] <= total_app;
      end
      if (last_row) rows_done_q <= 1'b1;
      if (comp_cnt != '0) any_nz_q <= 1'b1;
    end else if (do_shift) begin
      stg_data_q <= stg_data_sh;
      stg_col_q  <= stg_col_sh;
      occ_q      <= occ_q - OCC_W'(N);
    end
  end
endmodule

// File: tb/tb_csr_packer.sv
// tb/tb_csr_packer.sv - randomized self-checking bench for csr_packer against a list-based packing model
module tb_csr_packer;
  import spmm_pkg::*;

`ifdef CSR_PACKER_ZERO_BEAT_EN
  localparam bit ZB = 1'b1;
`else
  localparam bit ZB = 1'b0;
`endif

  typedef struct {
    ptr_t  [N-1:0] ptr;
    col_t  [N-1:0] col;
    data_t [N-1:0] data;
    logic          last;
    int            after_row;
    int            wait_cyc;
  } beat_t;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          row_valid = 1'b0;
  logic          row_ready;
  data_t [N-1:0] row_data = '0;
  logic          lhs_start;
  logic          lhs_ready = 1'b0;
  ptr_t  [N-1:0] lhs_ptr;
  col_t  [N-1:0] lhs_col;
  data_t [N-1:0] lhs_data;
  logic          lhs_last;

  int    n_cmp = 0;
  int    n_bad = 0;
  data_t mat [N][N];
  beat_t got_q[$];
  beat_t exp_q[$];

  always #5 clock = ~clock;

  csr_packer dut (
    .clock     (clock),
    .reset     (reset),
    .row_valid (row_valid),
    .row_ready (row_ready),
    .row_data  (row_data),
    .lhs_start (lhs_start),
    .lhs_ready (lhs_ready),
    .lhs_ptr   (lhs_ptr),
    .lhs_col   (lhs_col),
    .lhs_data  (lhs_data),
    .lhs_last  (lhs_last)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
    $fatal(1);
  end

  function automatic data_t rnd_nz();
    return data_t'($urandom_range((1 << W) - 1, 1));
  endfunction

  task automatic clear_mat();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) mat[i][j] = '0;
  endtask

  // Expected beats: nonzeros in row-major order; a beat leaves as soon as N are pending,
  // the matrix closes with whatever remains (or an empty beat when anything was seen).
  task automatic build_model(input int nrows);
    col_t  pc[$];
    data_t pv[$];
    int    cum[N];
    int    total = 0;
    bit    anynz = 0;
    bit    last_done;
    beat_t b;
    exp_q.delete();
    for (int i = 0; i < nrows; i++) begin
      for (int j = 0; j < N; j++) begin
        if (mat[i][j] != '0) begin
          pc.push_back(col_t'(j));
          pv.push_back(mat[i][j]);
          total++;
          anynz = 1;
        end
      end
      cum[i] = total;
      last_done = 0;
      while (pc.size() >= N) begin
        for (int k = 0; k < N; k++) begin
          b.col[k]  = pc.pop_front();
          b.data[k] = pv.pop_front();
          b.ptr[k]  = ptr_t'(cum[(k <= i) ? k : i]);
        end
        b.last = (i == N - 1) && (pc.size() == 0);
        last_done = b.last;
        b.after_row = i + 1;
        b.wait_cyc = 0;
        exp_q.push_back(b);
      end
      if (i == N - 1 && !last_done && (anynz || ZB)) begin
        for (int k = 0; k < N; k++) begin
          if (pc.size() > 0) begin
            b.col[k]  = pc.pop_front();
            b.data[k] = pv.pop_front();
          end else begin
            b.col[k]  = '0;
            b.data[k] = '0;
          end
          b.ptr[k] = ptr_t'(cum[k]);
        end
        b.last = 1'b1;
        b.after_row = N;
        b.wait_cyc = 0;
        exp_q.push_back(b);
      end
    end
  endtask

  // Feeds rows 0..nrows-1 of mat and collects beats; checks hold-while-stalled and no input while pending.
  task automatic run_matrix(input int nrows, input int ready_pct, input int stall,
                            output int beats_bad, output int stable_bad, output bit timed_out);
    int    r = 0;
    int    idle = 0;
    int    cyc = 0;
    int    stall_left;
    bit    in_beat = 0;
    beat_t cur;
    got_q.delete();
    beats_bad = 0;
    stable_bad = 0;
    timed_out = 0;
    stall_left = stall;
    while (!(r == nrows && idle >= 4)) begin
      @(negedge clock);
      cyc++;
      if (cyc > 3000) begin
        timed_out = 1;
        break;
      end
      if (lhs_start) begin
        idle = 0;
        row_valid = 1'b0;
        if (!in_beat) begin
          cur.ptr = lhs_ptr;
          cur.col = lhs_col;
          cur.data = lhs_data;
          cur.last = lhs_last;
          cur.after_row = r;
          cur.wait_cyc = 0;
          in_beat = 1;
        end else if (lhs_ptr !== cur.ptr || lhs_col !== cur.col || lhs_data !== cur.data || lhs_last !== cur.last) begin
          stable_bad++;
          $display("  beat %0d changed while stalled", got_q.size());
        end
        if (row_ready !== 1'b0) begin
          stable_bad++;
          $display("  row_ready=%b while beat %0d pending", row_ready, got_q.size());
        end
        cur.wait_cyc++;
        if (stall_left > 0) begin
          lhs_ready = 1'b0;
          stall_left--;
        end else begin
          lhs_ready = ($urandom_range(99) < ready_pct);
        end
        if (lhs_ready) begin
          got_q.push_back(cur);
          in_beat = 0;
        end
      end else begin
        lhs_ready = 1'($urandom_range(1));
        if (r < nrows && $urandom_range(3) != 0) begin
          row_valid = 1'b1;
          for (int j = 0; j < N; j++) row_data[j] = mat[r][j];
          if (row_ready) r++;
        end else begin
          row_valid = 1'b0;
          if (r == nrows) idle++;
        end
      end
    end
    row_valid = 1'b0;
    lhs_ready = 1'b0;
    if (got_q.size() != exp_q.size())
      beats_bad += (got_q.size() > exp_q.size()) ? got_q.size() - exp_q.size() : exp_q.size() - got_q.size();
    for (int b = 0; b < got_q.size() && b < exp_q.size(); b++) begin
      if (got_q[b].ptr !== exp_q[b].ptr || got_q[b].col !== exp_q[b].col || got_q[b].data !== exp_q[b].data ||
          got_q[b].last !== exp_q[b].last || got_q[b].after_row != exp_q[b].after_row) begin
        beats_bad++;
        $display("  beat %0d: ptr %h/%h col %h/%h data %h/%h last %b/%b row %0d/%0d", b,
                 got_q[b].ptr, exp_q[b].ptr, got_q[b].col, exp_q[b].col, got_q[b].data, exp_q[b].data,
                 got_q[b].last, exp_q[b].last, got_q[b].after_row, exp_q[b].after_row);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clock);
    n_cmp++;
    if (row_ready !== 1'b0 || lhs_start !== 1'b0 || lhs_last !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl: row_ready/lhs_start/lhs_last = %b%b%b, required 000", row_ready, lhs_start, lhs_last);
    end
    n_cmp++;
    if (lhs_ptr !== '0 || lhs_col !== '0 || lhs_data !== '0) begin
      n_bad++;
      $display("FAIL reset_slots: ptr=%h col=%h data=%h, required all 0", lhs_ptr, lhs_col, lhs_data);
    end
    reset = 1'b1;
    @(negedge clock);
    n_cmp++;
    if (row_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_release: row_ready=%b, required 1", row_ready);
    end
  endtask

  task automatic test_identity();
    int bb, sb;
    bit to;
    clear_mat();
    for (int i = 0; i < N; i++) mat[i][i] = data_t'(1);
    build_model(N);
    run_matrix(N, 100, 0, bb, sb, to);
    n_cmp++;
    if (got_q.size() !== 1 || to) begin
      n_bad++;
      $display("FAIL identity_count: beats=%0d timeout=%0d, required 1 beat", got_q.size(), to);
    end
    n_cmp++;
    if (got_q.size() > 0 && (got_q[0].ptr[N-1] !== ptr_t'(N) || got_q[0].last !== 1'b1)) begin
      n_bad++;
      $display("FAIL identity_last: ptr[N-1]=%0d last=%b, required %0d and 1", got_q[0].ptr[N-1], got_q[0].last, N);
    end
    n_cmp++;
    if (bb !== 0 || sb !== 0) begin
      n_bad++;
      $display("FAIL identity_beats: bad beats=%0d unstable=%0d, required 0/0", bb, sb);
    end
  endtask

  task automatic test_dense();
    int bb, sb;
    bit to;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) mat[i][j] = data_t'(1);
    build_model(N);
    run_matrix(N, 70, 0, bb, sb, to);
    n_cmp++;
    if (got_q.size() !== N || to) begin
      n_bad++;
      $display("FAIL dense_count: beats=%0d timeout=%0d, required %0d", got_q.size(), to, N);
    end
    n_cmp++;
    if (got_q.size() > 0 && (got_q[got_q.size()-1].ptr[N-1] !== '0 || got_q[got_q.size()-1].last !== 1'b1)) begin
      n_bad++;
      $display("FAIL dense_wrap: final ptr[N-1]=%0d last=%b, required 0 and 1",
               got_q[got_q.size()-1].ptr[N-1], got_q[got_q.size()-1].last);
    end
    n_cmp++;
    if (bb !== 0 || sb !== 0) begin
      n_bad++;
      $display("FAIL dense_beats: bad beats=%0d unstable=%0d, required 0/0", bb, sb);
    end
  endtask

  task automatic test_two_rows();
    int bb, sb, t;
    int perm[N];
    bit to;
    clear_mat();
    for (int r = 0; r < 2; r++) begin
      for (int j = 0; j < N; j++) perm[j] = j;
      for (int j = 0; j < N; j++) begin
        int s = $urandom_range(N - 1, j);
        t = perm[j];
        perm[j] = perm[s];
        perm[s] = t;
      end
      for (int k = 0; k < 10; k++) mat[r][perm[k]] = rnd_nz();
    end
    build_model(N);
    run_matrix(N, 60, 0, bb, sb, to);
    n_cmp++;
    if (got_q.size() !== 2 || to) begin
      n_bad++;
      $display("FAIL two_rows_count: beats=%0d timeout=%0d, required 2", got_q.size(), to);
    end
    n_cmp++;
    if (got_q.size() == 2 && got_q[1].data[N-1:4] !== '0) begin
      n_bad++;
      $display("FAIL two_rows_pad: final beat upper slots=%h, required 0", got_q[1].data[N-1:4]);
    end
    n_cmp++;
    if (bb !== 0 || sb !== 0) begin
      n_bad++;
      $display("FAIL two_rows_beats: bad beats=%0d unstable=%0d, required 0/0", bb, sb);
    end
  endtask

  task automatic test_stall();
    int bb, sb;
    bit to;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) mat[i][j] = ($urandom_range(99) < 50) ? rnd_nz() : '0;
    build_model(N);
    run_matrix(N, 100, 5, bb, sb, to);
    n_cmp++;
    if (got_q.size() == 0 || got_q[0].wait_cyc != 6 || to) begin
      n_bad++;
      $display("FAIL stall_wait: first beat presented %0d cycles (beats=%0d), required 6",
               (got_q.size() > 0) ? got_q[0].wait_cyc : 0, got_q.size());
    end
    n_cmp++;
    if (bb !== 0 || sb !== 0) begin
      n_bad++;
      $display("FAIL stall_beats: bad beats=%0d unstable=%0d, required 0/0", bb, sb);
    end
  endtask

  task automatic test_zero();
    int bb, sb;
    bit to;
    clear_mat();
    build_model(N);
    run_matrix(N, 100, 0, bb, sb, to);
    n_cmp++;
    if (got_q.size() !== exp_q.size() || bb !== 0 || to) begin
      n_bad++;
      $display("FAIL zero_matrix: beats=%0d bad=%0d timeout=%0d, required %0d beats, 0 bad", got_q.size(), bb, to, exp_q.size());
    end
  endtask

  task automatic test_random();
    int bb, sb, dens;
    bit to;
    for (int m = 0; m < 6; m++) begin
      dens = $urandom_range(90, 5);
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) mat[i][j] = ($urandom_range(99) < dens) ? rnd_nz() : '0;
      build_model(N);
      run_matrix(N, $urandom_range(100, 30), 0, bb, sb, to);
      n_cmp++;
      if (got_q.size() !== exp_q.size() || bb !== 0 || sb !== 0 || to) begin
        n_bad++;
        $display("FAIL random_%0d: beats=%0d/%0d bad=%0d unstable=%0d timeout=%0d, required equal counts and 0",
                 m, got_q.size(), exp_q.size(), bb, sb, to);
      end
    end
  endtask

  task automatic test_reset_mid();
    int bb, sb;
    bit to;
    clear_mat();
    for (int i = 0; i < 8; i++) mat[i][$urandom_range(N - 1)] = rnd_nz();
    build_model(8);
    run_matrix(8, 100, 0, bb, sb, to);
    n_cmp++;
    if (got_q.size() !== 0 || to) begin
      n_bad++;
      $display("FAIL partial_no_beat: beats=%0d timeout=%0d, required 0", got_q.size(), to);
    end
    #2;
    reset = 1'b0;
    #1;
    n_cmp++;
    if (lhs_ptr !== '0 || row_ready !== 1'b0 || lhs_start !== 1'b0) begin
      n_bad++;
      $display("FAIL async_reset: ptr=%h row_ready=%b lhs_start=%b, required 0", lhs_ptr, row_ready, lhs_start);
    end
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) mat[i][j] = ($urandom_range(99) < 30) ? rnd_nz() : '0;
    build_model(N);
    run_matrix(N, 80, 0, bb, sb, to);
    n_cmp++;
    if (got_q.size() !== exp_q.size() || bb !== 0 || sb !== 0 || to) begin
      n_bad++;
      $display("FAIL after_reset: beats=%0d/%0d bad=%0d unstable=%0d timeout=%0d, required equal counts and 0",
               got_q.size(), exp_q.size(), bb, sb, to);
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_dense();
    test_two_rows();
    test_stall();
    test_zero();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/csr_packer.md
CSR_PACKER -- requirements
Module: csr_packer

Interface
REQ-001 SHALL have parameter-like macro N: default 16; matrix dimension and slots per beat.
REQ-002 SHALL have macro W: default 8; element width.
REQ-003 SHALL have macro lgN: default $clog2(N); column/row index width.
REQ-004 SHALL have macro dbLgN: default 2*$clog2(N); pointer width.
REQ-005 clock  in  1  single clock; all state on rising edge.
REQ-006 reset  in  1  asynchronous, active-low.
REQ-007 row_valid  in  1  dense row offered.
REQ-008 row_ready  out  1  row accepted when row_valid&&row_ready.
REQ-009 row_data  in  data_t[N]  dense row, element j = column j.
REQ-010 lhs_start  out  1  beat offered to SpMM lhs port; held until taken.
REQ-011 lhs_ready  in  1  beat transferred when lhs_start&&lhs_ready.
REQ-012 lhs_ptr  out  [dbLgN-1:0][N]  cumulative nonzero count through row i.
REQ-013 lhs_col  out  [lgN-1:0][N]  column of each slot.
REQ-014 lhs_data  out  data_t[N]  value of each slot.
REQ-015 lhs_last  out  1  beat is final beat of the matrix.

Function
REQ-016 SHALL pack exactly N rows per matrix, row i = i-th accepted row; row counter lgN bits, wraps to 0 after row N-1.
REQ-017 SHALL compact nonzeros of each row in ascending column order and append to a 2N-entry staging buffer with occupancy count.
REQ-018 SHALL keep ptr table: on accepting row i, ptr[i..N-1] <= running total including row i; table cleared at matrix start.
REQ-019 ptr arithmetic SHALL be modulo 2^dbLgN (fully dense matrix: ptr[N-1] = 0).
REQ-020 States: FILL, SEND, SEND_LAST; reset state FILL.
REQ-021 FILL: row_ready=1; after accept, occupancy>=N -> SEND; row N-1 accepted and occupancy<N -> SEND_LAST.
REQ-022 SEND: lhs_start=1, lhs_last=0, slots = staging[0..N-1]; on transfer shift staging by N; then occupancy>=N stay SEND, else if row N-1 done -> SEND_LAST, else FILL.
REQ-023 SEND when row N-1 done and occupancy==N exactly: that beat SHALL carry lhs_last=1 and return to FILL.
REQ-024 SEND_LAST: lhs_start=1, lhs_last=1, unused slots col=0 data=0; on transfer clear ptr table, occupancy, -> FILL.
REQ-025 row_ready SHALL be 0 in SEND and SEND_LAST (no input while beat pending).
REQ-026 Latency: lhs_start SHALL rise the cycle after the accepting edge that fills a beat.
REQ-027 lhs_ptr SHALL show the ptr table as registered at beat presentation; outputs stable while lhs_start&&!lhs_ready.
REQ-028 Zero rows SHALL advance row counter and ptr only.

Reset
REQ-029 reset low SHALL immediately force FILL, occupancy 0, row counter 0, ptr table 0, lhs_start 0, lhs_last 0, row_ready 0 while asserted; outputs lhs_col/lhs_data/lhs_ptr 0.
REQ-030 Reset mid-matrix SHALL discard partial matrix; no beat emitted for it.

Configuration
REQ-031 Macro CSR_PACKER_ZERO_BEAT_EN: defined -> all-zero matrix emits one SEND_LAST beat (all slots 0, ptr all 0); undefined -> all-zero matrix emits no beat, returns to FILL silently.

Structure
REQ-032 Package spmm_pkg SHALL hold N, W, lgN, dbLgN and data_t, shared with SpMM.
REQ-033 Sub-module row_compactor SHALL be combinational: row -> compacted values, columns, nonzero count (prefix sum).

Verification
REQ-034 Identity matrix (N=16): 16 rows, 1 nonzero each -> one beat, lhs_last=1, col[i]=i, data 1, ptr[i]=i+1.
REQ-035 Fully dense all-1 matrix -> 16 beats, last has lhs_last=1, ptr[i]=16*(i+1) mod 256 (ptr[15]=0).
REQ-036 Row0 10 nonzeros, row1 10 nonzeros, rest zero -> beat1 slots = row0[10]+row1 first 6, row_ready low while pending; final beat 4 slots, 12 padded zero.
REQ-037 lhs_ready held low 5 cycles during SEND -> outputs unchanged, row_ready 0, transfer on 6th.
REQ-038 All-zero matrix -> one zero beat with macro, no beat without.
REQ-039 reset asserted after row 7 -> no beat; next matrix packs cleanly from row 0.
